// File: rtl/port_rr_arbiter_pkg.sv
// port_rr_arbiter_pkg: flit geometry, direction indices and arbiter state encoding
package port_rr_arbiter_pkg;
  localparam int HDR_SZ = 4;
  localparam int PL_SZ = 8;
  localparam int ADDR_SZ = 4;
  localparam int FLIT_W = HDR_SZ + PL_SZ + ADDR_SZ;
  localparam int DIRECTIONS = 5;
  localparam int NORTH = 0;
  localparam int EAST = 1;
  localparam int SOUTH = 2;
  localparam int WEST = 3;
  localparam int LOCAL = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT_ACK = 2'd1,
    SEND = 2'd2
  } state_t;
endpackage

// File: rtl/port_rr_arbiter_if.sv
// port_rr_arbiter_if: requester/transmitter signals of one output port
interface port_rr_arbiter_if
  import port_rr_arbiter_pkg::*;
#(
  parameter int NREQ = DIRECTIONS,
  parameter int W = FLIT_W
);
  logic [NREQ-1:0] req;
  logic [NREQ*W-1:0] item_in;
  logic [NREQ-1:0] read;
  logic [W-1:0] item_out;
  logic ena;
  logic busy;
  logic [2:0] grant_id;
  logic timeout_err;
  modport master (
    input req, item_in, busy,
    output read, item_out, ena, grant_id, timeout_err
  );
  modport slave (
    output req, item_in, busy,
    input read, item_out, ena, grant_id, timeout_err
  );
endinterface

// File: rtl/port_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search starting at ptr
module rr_pick #(
  parameter int NREQ = 5
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [2:0]      winner,
  output logic            valid
);
  logic [2:0] idx;
  // scan offsets from farthest to nearest so the closest requester at or after ptr wins
  always_comb begin
    winner = '0;
    idx = '0;
    valid = |req;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = 3'((int'(ptr) + i) % NREQ);
      if (req[idx]) winner = idx;
    end
  end
endmodule

// File: rtl/port_rr_arbiter.sv
// port_rr_arbiter: round-robin grant, pop and transmit sequencing for one output port
module port_rr_arbiter
  import port_rr_arbiter_pkg::*;
#(
  parameter int NREQ = DIRECTIONS,
  parameter int W = FLIT_W,
  parameter int ACK_TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  port_rr_arbiter_if.master bus
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  state_t state, state_nx;
  logic [2:0] ptr, winner;
  logic [CW-1:0] cnt;
  logic valid, grant, tmo;
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req(bus.req),
    .ptr(ptr),
    .winner(winner),
    .valid(valid)
  );
  // grant decision, ack timeout detection and next state
  always_comb begin
    grant = state == IDLE && valid && !bus.busy;
    tmo = state == WAIT_ACK && !bus.busy && cnt == CW'(ACK_TIMEOUT - 1);
    state_nx = state;
    case (state)
      IDLE: state_nx = grant ? WAIT_ACK : IDLE;
      WAIT_ACK: state_nx = bus.busy ? SEND : tmo ? IDLE : WAIT_ACK;
      SEND: state_nx = bus.busy ? SEND : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state register; reset abandons any transfer in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // registered grant outputs, flit latch, pointer and ack wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.read <= '0;
      bus.ena <= 1'b0;
      bus.item_out <= '0;
      bus.grant_id <= '0;
      bus.timeout_err <= 1'b0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      bus.ena <= grant;
      bus.read <= grant ? NREQ'(1) << winner : '0;
      if (grant) begin
        bus.item_out <= W'(bus.item_in >> (int'(winner) * W));
        bus.grant_id <= winner;
        ptr <= winner == 3'(NREQ - 1) ? 3'd0 : winner + 3'd1;
      end
      cnt <= (state == WAIT_ACK && !bus.busy && !tmo) ? cnt + 1'b1 : '0;
      if (tmo) bus.timeout_err <= 1'b1;
    end
  end
endmodule

// File: doc/port_rr_arbiter.md
# port_rr_arbiter

Round-robin arbiter and sequencer for a single router output port. It shares one serializing transmitter (or the parallel local output) among up to NREQ input FIFOs. It picks a winner, pops that FIFO, hands the flit to the transmitter with a one-cycle enable, then holds the port until the transmitter finishes. One instance sits between the input FIFOs and each output transmitter, replacing the per-port arbitration inside the routing logic.

## Interface
Parameters:
- NREQ, 5, number of requesters (N, E, S, W, L in bit order 0..4)
- W, `HDR_SZ+`PL_SZ+`ADDR_SZ, flit width
- ACK_TIMEOUT, 255, max cycles to wait for `busy` to rise after `ena`

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req  in  NREQ  requester i has a head flit routed to this port (FIFO non-empty and route matches)
- item_in  in  NREQ*W  head flits; requester i occupies bits [i*W +: W]
- read  out  NREQ  one-hot FIFO pop pulse, one cycle
- item_out  out  W  latched flit of the current grant
- ena  out  1  transmit request pulse, one cycle
- busy  in  1  transmitter busy (tx_busy)
- grant_id  out  3  index of the last winner
- timeout_err  out  1  sticky: the transmitter never acknowledged a grant

## Operation
- States: IDLE, WAIT_ACK, SEND.
- IDLE: if `|req && !busy`, pick the winner by scanning from `ptr` upward, mod NREQ.
  - At that edge: `item_out <= item_in[winner]`, `ena <= 1`, `read <= onehot(winner)`, `grant_id <= winner`, `ptr <= (winner+1) mod NREQ`, go to WAIT_ACK.
- IDLE with `busy` high: no grant, regardless of `req`.
- WAIT_ACK: `ena`/`read` return to 0.
  - `busy`=1 → SEND.
  - Otherwise the timeout counter increments. On reaching ACK_TIMEOUT: set `timeout_err`, go to IDLE. The flit is dropped; the pop has already happened.
- SEND: wait for `busy`=0, then go to IDLE. `req` changes are ignored here.
- `req` is sampled only in IDLE. A requester deasserting before being chosen is simply skipped.
- `item_out` holds its value until the next grant.
- Pointer arithmetic: `ptr` is 3 bits, and wraps from NREQ-1 to 0 without ever taking a value ≥ NREQ.
- Reset (any state): state=IDLE, ptr=0, read=0, ena=0, item_out=0, grant_id=0, timeout_err=0, counter=0. A transfer in progress is abandoned.
- `timeout_err` clears only on reset.

## Timing
- Grant latency: 1 cycle. `req` seen in IDLE at edge k → `ena`/`read` high during cycle k+1 only.
- `ena` and `read` are registered, coincident, and never high for two consecutive cycles.
- Minimum grant-to-grant spacing: 3 cycles (IDLE→WAIT_ACK→SEND→IDLE), plus the transmitter busy duration.
- Timeout counter: ACK_TIMEOUT wait cycles counted in WAIT_ACK. With ACK_TIMEOUT=255, IDLE is re-entered on the 256th cycle after `ena`.
- `busy` rising in the same cycle `ena` is high is accepted: WAIT_ACK sees `busy`=1 at the next edge and goes directly to SEND.
- Simultaneous requests resolve in a single cycle. No combinational path from `req`, `item_in` or `busy` to any output.

## Structure
- Shared package/defines: `HDR_SZ`, `PL_SZ`, `ADDR_SZ`, `DIRECTIONS`, direction indices (`NORTH`..`LOCAL`), and the state encoding (IDLE=0, WAIT_ACK=1, SEND=2).
- One natural sub-module: `rr_pick`, purely combinational. Inputs `req` and `ptr`; outputs the winner index and a `valid` flag. It can be reused by other per-port arbiters.
- The FSM, timeout counter, flit latch and pointer live in the top module.

## Test plan
- Single request: req=5'b00100, busy=0, item_in[2]=0xA5A5 → next cycle ena=1, read=5'b00100, item_out=0xA5A5, grant_id=2. Then busy high 10 cycles, then low → IDLE.
- Fairness: req=5'b11111 held, busy pulses 4 cycles per grant → grant_id sequence 0,1,2,3,4,0. Each read bit pulses exactly once per round.
- Skip and wrap: ptr=4 (after granting 3), req=5'b01001 → winner 0, ptr becomes 1. Next winner 3.
- Blocked port: busy=1 in IDLE, req=5'b00001 for 20 cycles → no ena, no read. Drop busy → ena on the following cycle.
- Timeout: grant with busy held 0 → timeout_err=1 and IDLE exactly 256 cycles after ena. A further req still grants normally, and timeout_err stays 1.
- Reset mid-SEND: assert reset while busy=1 → all outputs 0 immediately (async), state IDLE, ptr=0. After release with req=5'b10000, busy=0 → grant_id=4.
